// File: rtl/shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the pipelined rotate/mask/sign-extend unit.
//   DEF_*           default widths and depth used by shift_pipe and its slices
//   shift_req_t     one request as presented on the input side
//                   {op, sh, mask, left, sx, tag} at the default widths
//   stage_of_layer  maps rotate layer i (amount 2^i) onto a pipeline stage so
//                   the LOG2W layers are spread evenly across STAGES registers
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_LOG2W  = $clog2(DEF_W);
    localparam int DEF_TAG_W  = 4;
    localparam int DEF_STAGES = 2;

    typedef struct packed {
        logic [DEF_W-1:0]     op;
        logic [DEF_LOG2W-1:0] sh;
        logic [DEF_LOG2W-1:0] mask;
        logic                 left;
        logic                 sx;
        logic [DEF_TAG_W-1:0] tag;
    } shift_req_t;

    // Layer i runs in stage floor(i*stages/log2w); with stages <= log2w every
    // stage index in 0..stages-1 is reachable and the mapping is monotonic.
    function automatic int stage_of_layer(input int layer, input int stages,
                                          input int log2w);
        return (layer * stages) / log2w;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// shift_pipe_stage
// One register slice of shift_pipe. The combinational path in front of the
// register applies the rotate layers owned by this slice (selected by
// stage_of_layer) and, in the final slice only, the mask and sign-extend step.
// Consumed rotate-amount bits are cleared so the carried eff field always shows
// the rotation still outstanding.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous drop of the held op
//   up_valid/ready  handshake with the previous slice (or the unit input)
//   up_data ...     operand, remaining rotate amount, mask, left, sx, tag in
//   dn_valid/ready  handshake with the next slice (or the unit output)
//   dn_data ...     registered copies of the same fields
// -----------------------------------------------------------------------------
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int  W      = DEF_W,
    parameter int  STAGES = DEF_STAGES,
    parameter int  TAG_W  = DEF_TAG_W,
    parameter int  IDX    = 0,
    localparam int LOG2W  = $clog2(W),
    localparam bit IS_LAST = (IDX == STAGES - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic [LOG2W-1:0] up_eff,
    input  logic [LOG2W-1:0] up_mask,
    input  logic             up_left,
    input  logic             up_sx,
    input  logic [TAG_W-1:0] up_tag,

    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [W-1:0]     dn_data,
    output logic [LOG2W-1:0] dn_eff,
    output logic [LOG2W-1:0] dn_mask,
    output logic             dn_left,
    output logic             dn_sx,
    output logic [TAG_W-1:0] dn_tag
);

    logic [W-1:0]     layer [LOG2W+1];
    logic [LOG2W-1:0] eff_next;
    logic [W-1:0]     data_next;

    logic             valid_reg;
    logic [W-1:0]     data_reg;
    logic [LOG2W-1:0] eff_reg;
    logic [LOG2W-1:0] mask_reg;
    logic             left_reg;
    logic             sx_reg;
    logic [TAG_W-1:0] tag_reg;

    assign layer[0] = up_data;

    // Rotate-right ladder: layer gi rotates by 2^gi when eff bit gi is set.
    // Layers owned by other slices pass the data straight through.
    genvar gi;
    generate
        for (gi = 0; gi < LOG2W; gi++) begin : g_layer
            localparam int AMT = 1 << gi;
            if (stage_of_layer(gi, STAGES, LOG2W) == IDX) begin : g_own
                assign layer[gi+1] = up_eff[gi]
                                   ? {layer[gi][AMT-1:0], layer[gi][W-1:AMT]}
                                   : layer[gi];
                assign eff_next[gi] = 1'b0;
            end else begin : g_pass
                assign layer[gi+1]  = layer[gi];
                assign eff_next[gi] = up_eff[gi];
            end
        end
    endgenerate

    generate
        if (IS_LAST) begin : g_mask
            logic [W-1:0] mask_r;
            logic [W-1:0] mask_l;
            logic [W-1:0] kept;
            always_comb begin
                mask_r    = {W{1'b1}} >> up_mask;
                mask_l    = {W{1'b1}} << up_mask;
                kept      = layer[LOG2W] & (up_left ? mask_l : mask_r);
                data_next = kept;
                // Top bit of the kept field in right mode is W-1-mask, which
                // equals ~mask because W is a power of two.
                if (!up_left && up_sx && kept[~up_mask]) begin
                    data_next = kept | ~mask_r;
                end
            end
        end else begin : g_nomask
            assign data_next = layer[LOG2W];
        end
    endgenerate

    // A slice can take a new op when empty or when its current op leaves.
    assign up_ready = !valid_reg || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            eff_reg   <= '0;
            mask_reg  <= '0;
            left_reg  <= 1'b0;
            sx_reg    <= 1'b0;
            tag_reg   <= '0;
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (up_ready) begin
                valid_reg <= up_valid;
            end
            // Payload only moves with a real transfer so a stalled or
            // emptied slice keeps presenting its last result.
            if (up_ready && up_valid && !flush) begin
                data_reg <= data_next;
                eff_reg  <= eff_next;
                mask_reg <= up_mask;
                left_reg <= up_left;
                sx_reg   <= up_sx;
                tag_reg  <= up_tag;
            end
        end
    end

    assign dn_valid = valid_reg;
    assign dn_data  = data_reg;
    assign dn_eff   = eff_reg;
    assign dn_mask  = mask_reg;
    assign dn_left  = left_reg;
    assign dn_sx    = sx_reg;
    assign dn_tag   = tag_reg;

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Pipelined, elastic rotate / mask / sign-extend unit with valid/ready
// handshake, opaque tag passthrough and synchronous flush.
//   res = rotr(op, left ? -sh : sh) & (left ? '1 << mask : '1 >> mask)
//   right mode with sx: the kept field is sign-extended from bit W-1-mask.
// Latency from accept to out_valid is STAGES cycles; throughput one op/cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      drop all in-flight ops (synchronous)
//   in_valid/in_ready          request handshake
//   in_op, in_sh, in_mask      operand, rotate amount, number of bits cleared
//   in_left, in_sx, in_tag     direction, sign-extend (right only), tag
//   out_valid/out_ready        result handshake
//   out_data, out_tag          result and its tag
// -----------------------------------------------------------------------------
module shift_pipe
    import shift_pkg::*;
#(
    parameter int  W      = DEF_W,
    parameter int  STAGES = DEF_STAGES,
    parameter int  TAG_W  = DEF_TAG_W,
    localparam int LOG2W  = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_op,
    input  logic [LOG2W-1:0] in_sh,
    input  logic [LOG2W-1:0] in_mask,
    input  logic             in_left,
    input  logic             in_sx,
    input  logic [TAG_W-1:0] in_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Index k is the input of slice k; index STAGES is the unit output.
    logic             s_valid [STAGES+1];
    logic             s_ready [STAGES+1];
    logic [W-1:0]     s_data  [STAGES+1];
    logic [LOG2W-1:0] s_eff   [STAGES+1];
    logic [LOG2W-1:0] s_mask  [STAGES+1];
    logic             s_left  [STAGES+1];
    logic             s_sx    [STAGES+1];
    logic [TAG_W-1:0] s_tag   [STAGES+1];

    assign in_ready   = s_ready[0] && !flush;
    assign s_valid[0] = in_valid && in_ready;
    assign s_data[0]  = in_op;
    // A left rotate by sh is a right rotate by -sh modulo W.
    assign s_eff[0]   = in_left ? (-in_sh) : in_sh;
    assign s_mask[0]  = in_mask;
    assign s_left[0]  = in_left;
    assign s_sx[0]    = in_sx;
    assign s_tag[0]   = in_tag;

    assign s_ready[STAGES] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            shift_pipe_stage #(
                .W      (W),
                .STAGES (STAGES),
                .TAG_W  (TAG_W),
                .IDX    (gi)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .up_valid (s_valid[gi]),
                .up_ready (s_ready[gi]),
                .up_data  (s_data[gi]),
                .up_eff   (s_eff[gi]),
                .up_mask  (s_mask[gi]),
                .up_left  (s_left[gi]),
                .up_sx    (s_sx[gi]),
                .up_tag   (s_tag[gi]),
                .dn_valid (s_valid[gi+1]),
                .dn_ready (s_ready[gi+1]),
                .dn_data  (s_data[gi+1]),
                .dn_eff   (s_eff[gi+1]),
                .dn_mask  (s_mask[gi+1]),
                .dn_left  (s_left[gi+1]),
                .dn_sx    (s_sx[gi+1]),
                .dn_tag   (s_tag[gi+1])
            );
        end
    endgenerate

    assign out_valid = s_valid[STAGES];
    assign out_data  = s_data[STAGES];
    assign out_tag   = s_tag[STAGES];

    // The final slice's control copies have no consumer once masking is done.
    logic unused_tail;
    assign unused_tail = ^{s_eff[STAGES], s_mask[STAGES], s_left[STAGES], s_sx[STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
// Self-checking bench for shift_pipe. Three instances share the request fields:
//   index 0: STAGES=2 (main), index 1: STAGES=1, index 2: STAGES=5.
// Directed table vectors, hand-written multi-cycle sequences (stall, flush,
// async reset) and a randomized run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_shift_pipe;
    import shift_pkg::*;

    typedef struct {
        shift_req_t  req;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_op;
    logic [4:0]  in_sh;
    logic [4:0]  in_mask;
    logic        in_left;
    logic        in_sx;
    logic [3:0]  in_tag;

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] out_data  [3];
    logic [3:0]  out_tag   [3];

    int checks   = 0;
    int failures = 0;

    shift_pipe #(.W(32), .STAGES(2), .TAG_W(4)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_op(in_op), .in_sh(in_sh), .in_mask(in_mask),
        .in_left(in_left), .in_sx(in_sx), .in_tag(in_tag),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_tag(out_tag[0])
    );

    shift_pipe #(.W(32), .STAGES(1), .TAG_W(4)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_op(in_op), .in_sh(in_sh), .in_mask(in_mask),
        .in_left(in_left), .in_sx(in_sx), .in_tag(in_tag),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_tag(out_tag[1])
    );

    shift_pipe #(.W(32), .STAGES(5), .TAG_W(4)) u_dut_s5 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_op(in_op), .in_sh(in_sh), .in_mask(in_mask),
        .in_left(in_left), .in_sx(in_sx), .in_tag(in_tag),
        .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(out_data[2]), .out_tag(out_tag[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: rotate by moving bits to their destination positions, then
    // keep the field by position and fill above it from its top bit.
    function automatic logic [31:0] ref_calc(input shift_req_t r);
        logic [31:0] rot;
        logic [31:0] res;
        int m;
        int s;
        rot = '0;
        res = '0;
        m = int'(r.mask);
        s = int'(r.sh);
        for (int j = 0; j < 32; j++) begin
            if (r.left) rot[(j + s) % 32] = r.op[j];
            else        rot[j] = r.op[(j + s) % 32];
        end
        for (int j = 0; j < 32; j++) begin
            if (r.left) res[j] = (j >= m) ? rot[j] : 1'b0;
            else        res[j] = (j < 32 - m) ? rot[j] : 1'b0;
        end
        if (!r.left && r.sx && rot[31 - m]) begin
            for (int j = 32 - m; j < 32; j++) res[j] = 1'b1;
        end
        return res;
    endfunction

    function automatic vec_t mk(input logic [31:0] op, input int sh, input int mask,
                                input logic left, input logic sx, input int tag,
                                input logic [31:0] exp);
        vec_t v;
        v.req.op   = op;
        v.req.sh   = 5'(sh);
        v.req.mask = 5'(mask);
        v.req.left = left;
        v.req.sx   = sx;
        v.req.tag  = 4'(tag);
        v.exp      = exp;
        return v;
    endfunction

    function automatic shift_req_t rand_req(input int tag);
        shift_req_t r;
        r.op   = $urandom;
        r.sh   = 5'($urandom_range(0, 31));
        r.mask = 5'($urandom_range(0, 31));
        r.left = 1'($urandom_range(0, 1));
        r.sx   = 1'($urandom_range(0, 1));
        r.tag  = 4'(tag);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input shift_req_t r);
        in_op   = r.op;
        in_sh   = r.sh;
        in_mask = r.mask;
        in_left = r.left;
        in_sx   = r.sx;
        in_tag  = r.tag;
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    // Single op through instance k with out_ready high; checks latency and result.
    task automatic single_op(input int k, input vec_t v);
        int  cyc;
        bit  got;
        @(negedge clk);
        drive_req(v.req);
        in_valid[k] = 1'b1;
        out_ready   = 1'b1;
        #1;
        chk("accept_ready", 32'(in_ready[k]), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            in_valid[k] = 1'b0;
            #1;
            cyc++;
            if (out_valid[k]) got = 1'b1;
        end
        chk("latency", 32'(cyc), 32'(lat_of(k)));
        chk("data", out_data[k], v.exp);
        chk("tag", 32'(out_tag[k]), 32'(v.req.tag));
        $display("op k=%0d op=%h sh=%0d mask=%0d left=%0b sx=%0b -> data=%h tag=%0d lat=%0d",
                 k, v.req.op, v.req.sh, v.req.mask, v.req.left, v.req.sx,
                 out_data[k], out_tag[k], cyc);
    endtask

    vec_t        tbl [10];
    shift_req_t  ops [8];
    logic [31:0] ops_exp [8];
    exp_t        q [$];

    initial begin
        int          next;
        int          rcv;
        logic [31:0] held_d;
        logic [3:0]  held_t;
        exp_t        e;
        shift_req_t  r;

        tbl[0] = mk(32'h12345678,  8,  8, 1'b0, 1'b0, 1, 32'h00123456);
        tbl[1] = mk(32'h89ABCDEF,  8,  8, 1'b0, 1'b1, 2, 32'hFF89ABCD);
        tbl[2] = mk(32'h89ABCDEF,  8,  8, 1'b0, 1'b0, 3, 32'h0089ABCD);
        tbl[3] = mk(32'h000000FF,  4,  8, 1'b1, 1'b1, 4, 32'h00000F00);
        tbl[4] = mk(32'hDEADBEEF,  0,  0, 1'b0, 1'b0, 5, 32'hDEADBEEF);
        tbl[5] = mk(32'hDEADBEEF,  0,  0, 1'b1, 1'b1, 6, 32'hDEADBEEF);
        tbl[6] = mk(32'h00000001,  0, 31, 1'b0, 1'b1, 7, 32'hFFFFFFFF);
        tbl[7] = mk(32'h12345678, 31,  0, 1'b1, 1'b0, 8, 32'h091A2B3C);
        tbl[8] = mk(32'hF0000000,  0, 31, 1'b1, 1'b0, 9, 32'h80000000);
        tbl[9] = mk(32'h0000ABCD,  0, 16, 1'b0, 1'b1, 10, 32'hFFFFABCD);

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
        drive_req(tbl[0].req);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", out_data[0], 32'd0);
        chk("rst_out_tag", 32'(out_tag[0]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_out_valid_s1", 32'(out_valid[1]), 32'd0);
        chk("rst_out_valid_s5", 32'(out_valid[2]), 32'd0);
        $display("reset released out_valid=%0b in_ready=%0b", out_valid[0], in_ready[0]);

        // Directed vectors on the STAGES=2 instance.
        for (int i = 0; i < 10; i++) single_op(0, tbl[i]);

        // Eight back-to-back ops, consumer stalls during cycles 3..5.
        for (int i = 0; i < 8; i++) begin
            ops[i]     = rand_req(i);
            ops_exp[i] = ref_calc(ops[i]);
        end
        next = 0;
        rcv = 0;
        held_d = '0;
        held_t = '0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            in_valid[0] = (next < 8);
            if (next < 8) drive_req(ops[next]);
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                chk("full_in_ready", 32'(in_ready[0]), 32'd0);
                chk("stall_valid", 32'(out_valid[0]), 32'd1);
                if (c > 3) begin
                    chk("stall_data", out_data[0], held_d);
                    chk("stall_tag", 32'(out_tag[0]), 32'(held_t));
                end
            end
            held_d = out_data[0];
            held_t = out_tag[0];
            if (out_valid[0] && out_ready) begin
                chk("b2b_tag", 32'(out_tag[0]), 32'(rcv));
                chk("b2b_data", out_data[0], ops_exp[rcv % 8]);
                $display("b2b cycle=%0d tag=%0d data=%h", c, out_tag[0], out_data[0]);
                rcv++;
            end
            if (in_valid[0] && in_ready[0]) next++;
        end
        in_valid[0] = 1'b0;
        chk("b2b_count", 32'(rcv), 32'd8);

        // Flush with two ops in flight and a request offered the same cycle.
        @(negedge clk);
        drive_req(tbl[1].req);
        in_valid[0] = 1'b1;
        out_ready   = 1'b0;
        #1;
        @(negedge clk);
        drive_req(tbl[2].req);
        #1;
        @(negedge clk);
        drive_req(tbl[3].req);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready[0]), 32'd0);
        chk("flush_pre_valid", 32'(out_valid[0]), 32'd1);
        @(negedge clk);
        flush       = 1'b0;
        in_valid[0] = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("flush_out_valid", 32'(out_valid[0]), 32'd0);
        $display("flush applied out_valid=%0b", out_valid[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("flush_drained", 32'(out_valid[0]), 32'd0);
        end
        single_op(0, tbl[0]);

        // Flush together with out_ready: the pending result still transfers.
        @(negedge clk);
        drive_req(tbl[1].req);
        in_valid[0] = 1'b1;
        out_ready   = 1'b0;
        #1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        @(negedge clk);
        #1;
        chk("flushxfer_valid", 32'(out_valid[0]), 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flushxfer_data", out_data[0], tbl[1].exp);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flushxfer_after", 32'(out_valid[0]), 32'd0);
        $display("flush+out_ready transfer data=%h", tbl[1].exp);

        // Asynchronous reset mid-stream.
        @(negedge clk);
        drive_req(tbl[0].req);
        in_valid[0] = 1'b1;
        out_ready   = 1'b0;
        #1;
        @(negedge clk);
        drive_req(tbl[1].req);
        #1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        chk("prerst_valid", 32'(out_valid[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid[0]), 32'd0);
        chk("async_rst_data", out_data[0], 32'd0);
        chk("async_rst_tag", 32'(out_tag[0]), 32'd0);
        $display("async reset out_valid=%0b data=%h tag=%0d", out_valid[0], out_data[0], out_tag[0]);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency on the other depths.
        single_op(1, tbl[0]);
        single_op(1, tbl[1]);
        single_op(2, tbl[0]);
        single_op(2, tbl[3]);

        // Randomized traffic with random stalls and occasional flush.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            r = rand_req(c % 16);
            drive_req(r);
            in_valid[0] = ($urandom_range(0, 9) < 6);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            if (out_valid[0] && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_spurious actual=%h required=no_output", out_data[0]);
                end else begin
                    e = q.pop_front();
                    chk("rand_data", out_data[0], e.d);
                    chk("rand_tag", 32'(out_tag[0]), 32'(e.t));
                    $display("rand cycle=%0d tag=%0d data=%h", c, out_tag[0], out_data[0]);
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid[0] && in_ready[0]) begin
                e.d = ref_calc(r);
                e.t = r.tag;
                q.push_back(e);
            end
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            #1;
            if (out_valid[0]) begin
                e = q.pop_front();
                chk("drain_data", out_data[0], e.d);
                chk("drain_tag", 32'(out_tag[0]), 32'(e.t));
                $display("drain tag=%0d data=%h", out_tag[0], out_data[0]);
            end
            @(negedge clk);
        end
        chk("rand_drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
